// File: rtl/fp16_pkg.sv
// fp16_pkg: shared types, constants and operand-classification helpers for
// the sequential binary16 multiplier.
//   state_t   : controller state encoding
//   EXP_W, FRAC_W, BIAS, MANT_W, PROD_W, E_W : field and datapath widths
//   QNAN, INF_MAG : canonical special-result encodings
//   is_nan / is_inf / is_zero / mant_of : operand helpers
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;
    localparam int E_W    = EXP_W + 2;

    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [14:0] INF_MAG = 15'h7C00;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        NORM = 3'd2,
        PACK = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic is_nan(input logic [15:0] x);
        return (&x[14:10]) && (|x[9:0]);
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (&x[14:10]) && !(|x[9:0]);
    endfunction

    // Subnormals are flushed, so any zero exponent field counts as zero.
    function automatic logic is_zero(input logic [15:0] x);
        return !(|x[14:10]);
    endfunction

    // Hidden bit is set only for a non-zero exponent; exp==0 yields m=0.
    function automatic logic [MANT_W-1:0] mant_of(input logic [15:0] x);
        if (|x[14:10])
            return {1'b1, x[9:0]};
        else
            return '0;
    endfunction

endpackage

// File: rtl/fp16_mul_seq_mul11x11.sv
// mul11x11: radix-2 shift-add unsigned 11x11 multiplier.
//   clk, reset : clock and synchronous active-high reset
//   start      : one-cycle load request (a, b sampled on this edge)
//   a, b       : 11-bit unsigned operands
//   done       : one-cycle pulse, p is the complete product while it is high
//   p          : 22-bit product, holds until the next start
// The start edge already folds in multiplier bit 0, nine further edges add
// bits 1..9, and bit 10 is added combinationally on the output. That keeps
// the full product visible during the done cycle without an extra edge.
module mul11x11
    import fp16_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MANT_W-1:0] a,
    input  logic [MANT_W-1:0] b,
    output logic              done,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] a_sh;
    logic [MANT_W-1:0] b_sh;
    logic [3:0]        cnt;
    logic [PROD_W-1:0] acc_nxt;

    assign acc_nxt = acc + (b_sh[0] ? a_sh : '0);
    // Once cnt reaches zero nothing shifts, so this stays equal to the product.
    assign p = acc_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc  <= b[0] ? {{MANT_W{1'b0}}, a} : '0;
                a_sh <= {{(MANT_W-1){1'b0}}, a, 1'b0};
                b_sh <= {1'b0, b[MANT_W-1:1]};
                cnt  <= 4'd9;
            end else if (cnt != 4'd0) begin
                acc  <= acc_nxt;
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                cnt  <= cnt - 4'd1;
                done <= (cnt == 4'd1);
            end
        end
    end

endmodule

// File: rtl/fp16_mul_seq.sv
// fp16_mul_seq: multi-cycle binary16 multiplier, f = f1 * f2.
//   clk, reset : clock and synchronous active-high reset
//   enable     : start request, honoured only in IDLE
//   f1, f2     : binary16 operands, held stable from enable until done
//   done       : one-cycle pulse when f is updated
//   f          : result, held until the next done pulse
// Mantissa is truncated and subnormals flush to zero. Every operation,
// including special operands, takes the same path so latency is constant:
// enable sampled on E0, f/done registered on E13, next start possible on E14.
module fp16_mul_seq
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] f1,
    input  logic [15:0] f2,
    output logic        done,
    output logic [15:0] f
);

    state_t state, state_nxt;

    logic              core_start;
    logic              core_done;
    logic [PROD_W-1:0] core_p;

    logic                  sign_r;
    logic                  nan_r;
    logic                  inf_r;
    logic                  zero_r;
    logic signed [E_W-1:0] exp_r;
    logic signed [E_W-1:0] exp_n_r;
    logic [FRAC_W-1:0]     frac_r;
    logic [15:0]           pack_r;
    logic [15:0]           pack_res;

    logic signed [E_W-1:0] e_sum;
    logic [FRAC_W-1:0]     frac_nxt;
    logic signed [E_W-1:0] exp_n_nxt;
    logic                  unused_p_bits;

    mul11x11 u_mul (
        .clk   (clk),
        .reset (reset),
        .start (core_start),
        .a     (mant_of(f1)),
        .b     (mant_of(f2)),
        .done  (core_done),
        .p     (core_p)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = MUL;
            MUL:     if (core_done) state_nxt = NORM;
            NORM:    state_nxt = PACK;
            PACK:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_start = (state == IDLE) && enable;

        pack_res = {sign_r, exp_n_r[EXP_W-1:0], frac_r};
        if (nan_r)
            pack_res = QNAN;
        else if (inf_r && zero_r)
            pack_res = QNAN;
        else if (inf_r)
            pack_res = {sign_r, INF_MAG};
        else if (zero_r)
            pack_res = {sign_r, 15'h0000};
        else if (exp_n_r >= 7'sd31)
            pack_res = {sign_r, INF_MAG};
        else if (exp_n_r <= 7'sd0)
            pack_res = {sign_r, 15'h0000};
    end

    // Seven signed bits cover the full range -15..47 of e1 + e2 - BIAS.
    assign e_sum = $signed({2'b00, f1[14:10]}) + $signed({2'b00, f2[14:10]})
                   - $signed(E_W'(BIAS));

    // Product of two [1,2) mantissas lies in [1,4): bit 21 decides the shift.
    assign frac_nxt  = core_p[PROD_W-1] ? core_p[PROD_W-2:FRAC_W+1]
                                        : core_p[PROD_W-3:FRAC_W];
    assign exp_n_nxt = core_p[PROD_W-1] ? exp_r + 7'sd1 : exp_r;

    // Truncated product bits are intentionally dropped.
    assign unused_p_bits = ^core_p[FRAC_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_r  <= 1'b0;
            nan_r   <= 1'b0;
            inf_r   <= 1'b0;
            zero_r  <= 1'b0;
            exp_r   <= '0;
            exp_n_r <= '0;
            frac_r  <= '0;
            pack_r  <= '0;
            f       <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (core_start) begin
                sign_r <= f1[15] ^ f2[15];
                nan_r  <= is_nan(f1) || is_nan(f2);
                inf_r  <= is_inf(f1) || is_inf(f2);
                zero_r <= is_zero(f1) || is_zero(f2);
                exp_r  <= e_sum;
            end
            if (state == NORM) begin
                frac_r  <= frac_nxt;
                exp_n_r <= exp_n_nxt;
            end
            if (state == PACK)
                pack_r <= pack_res;
            if (state == DONE) begin
                f    <= pack_r;
                done <= 1'b1;
            end
        end
    end

endmodule
